// File: rtl/free_list_mp.sv
// Multi-port physical-register free list: circular FIFO of free preg IDs with
// all-or-nothing group allocation, compacted multi-lane frees and head checkpoint/restore.
// Optional statistics (min_free_count, stall_cycles) are built when FREE_LIST_STATS_EN is defined.
module free_list_mp #(
  parameter int NUM_PREGS = 128,
  parameter int NUM_ARCH  = 32,
  parameter int ALLOC_W   = 2,
  parameter int FREE_W    = 2,
  localparam int PREG_W   = $clog2(NUM_PREGS),
  localparam int D        = NUM_PREGS - NUM_ARCH,
  localparam int PTR_W    = $clog2(2 * D),
  localparam int CNT_W    = $clog2(D + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ALLOC_W-1:0]              alloc_req,
  output logic [ALLOC_W-1:0][PREG_W-1:0]  alloc_preg,
  output logic                            alloc_stall,
  input  logic [FREE_W-1:0]               free_en,
  input  logic [FREE_W-1:0][PREG_W-1:0]   free_preg,
  output logic [PTR_W-1:0]                checkpoint_ptr,
  input  logic                            restore_en,
  input  logic [PTR_W-1:0]                restore_ptr,
  output logic [CNT_W-1:0]                free_count,
  output logic                            overflow_err
`ifdef FREE_LIST_STATS_EN
  ,
  output logic [CNT_W-1:0]                min_free_count,
  output logic [31:0]                     stall_cycles
`endif
);

  localparam int SW = PTR_W + 3;
  localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
  localparam logic [SW-1:0] D_S     = SW'(D);
  localparam logic [SW-1:0] TWO_D_S = SW'(2 * D);

  logic [PREG_W-1:0] mem_q [D];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic              ovf_q, ovf_d;

  logic [SW-1:0]     k_s, cnt_s, pre_s, space_s, slot_s, nacc_s;
  logic [FREE_W-1:0] we_s;
  logic [IDX_W-1:0]  widx_s [FREE_W];

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [SW-1:0] n);
    logic [SW-1:0] s;
    s = SW'(p) + n;
    if (s >= TWO_D_S) s = s - TWO_D_S;
    return s[PTR_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] idx(input logic [PTR_W-1:0] p);
    logic [SW-1:0] s;
    s = SW'(p);
    if (s >= D_S) s = s - D_S;
    return s[IDX_W-1:0];
  endfunction

  function automatic logic [SW-1:0] pdiff(input logic [PTR_W-1:0] t, input logic [PTR_W-1:0] h);
    if (t >= h) return SW'(t) - SW'(h);
    return SW'(t) + TWO_D_S - SW'(h);
  endfunction

  // Handshake: alloc_req is the request; a group is granted only in a cycle where
  // alloc_stall is low and restore_en is low. A stalled group must be re-presented.
  always_comb begin
    k_s = '0;
    for (int i = 0; i < ALLOC_W; i++) k_s = k_s + SW'(alloc_req[i]);
    cnt_s          = pdiff(tail_q, head_q);
    free_count     = cnt_s[CNT_W-1:0];
    checkpoint_ptr = head_q;
    overflow_err   = ovf_q;
    alloc_stall    = (k_s > cnt_s) && !restore_en;

    pre_s = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      alloc_preg[i] = mem_q[idx(ptr_add(head_q, pre_s))];
      pre_s = pre_s + SW'(alloc_req[i]);
    end

    head_d = head_q;
    if (restore_en) head_d = restore_ptr;
    else if (!alloc_stall) head_d = ptr_add(head_q, k_s);

    // Room is measured against the post-allocation head so same-cycle grants free slots.
    space_s = D_S - pdiff(tail_q, head_d);
    slot_s  = '0;
    nacc_s  = '0;
    for (int j = 0; j < FREE_W; j++) begin
      we_s[j]   = 1'b0;
      widx_s[j] = idx(ptr_add(tail_q, slot_s));
      if (free_en[j]) begin
        if (slot_s < space_s) begin
          we_s[j] = 1'b1;
          nacc_s  = nacc_s + SW'(1);
        end
        slot_s = slot_s + SW'(1);
      end
    end
    tail_d = ptr_add(tail_q, nacc_s);
    ovf_d  = ovf_q | (slot_s > space_s);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= PTR_W'(D);
      ovf_q  <= 1'b0;
      for (int i = 0; i < D; i++) mem_q[i] <= PREG_W'(NUM_ARCH + i);
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      ovf_q  <= ovf_d;
      for (int j = 0; j < FREE_W; j++) begin
        if (we_s[j]) mem_q[widx_s[j]] <= free_preg[j];
      end
    end
  end

`ifdef FREE_LIST_STATS_EN
  logic [CNT_W-1:0] min_q;
  logic [31:0]      stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q   <= CNT_W'(D);
      stall_q <= '0;
    end else begin
      if (free_count < min_q) min_q <= free_count;
      if (alloc_stall && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
    end
  end

  assign min_free_count = min_q;
  assign stall_cycles   = stall_q;
`endif

endmodule

// File: tb/tb_free_list_mp.sv
// Directed bench for free_list_mp (default parameters): reset, overflow, bulk
// allocation to empty, stall, free/realloc, checkpoint restore and pointer wrap.
module tb_free_list_mp;
  localparam int PREG_W = 7;
  localparam int PTR_W  = 8;
  localparam int CNT_W  = 7;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [1:0]             alloc_req;
  logic [1:0][PREG_W-1:0] alloc_preg;
  logic                   alloc_stall;
  logic [1:0]             free_en;
  logic [1:0][PREG_W-1:0] free_preg;
  logic [PTR_W-1:0]       checkpoint_ptr;
  logic                   restore_en;
  logic [PTR_W-1:0]       restore_ptr;
  logic [CNT_W-1:0]       free_count;
  logic                   overflow_err;
`ifdef FREE_LIST_STATS_EN
  logic [CNT_W-1:0]       min_free_count;
  logic [31:0]            stall_cycles;
`endif

  int checks = 0;
  int failures = 0;

  free_list_mp dut (
    .clk(clk),
    .rst(rst),
    .alloc_req(alloc_req),
    .alloc_preg(alloc_preg),
    .alloc_stall(alloc_stall),
    .free_en(free_en),
    .free_preg(free_preg),
    .checkpoint_ptr(checkpoint_ptr),
    .restore_en(restore_en),
    .restore_ptr(restore_ptr),
    .free_count(free_count),
    .overflow_err(overflow_err)
`ifdef FREE_LIST_STATS_EN
    ,
    .min_free_count(min_free_count),
    .stall_cycles(stall_cycles)
`endif
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req   = 2'b00;
    free_en     = 2'b00;
    free_preg   = '0;
    restore_en  = 1'b0;
    restore_ptr = '0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_count", free_count, 96);
    chk("rst_ckpt", checkpoint_ptr, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_stall", alloc_stall, 0);

    // Free into a full list: dropped, sticky error
    free_en = 2'b01; free_preg[0] = 7'd7;
    tick();
    idle();
    settle();
    chk("ovf_set", overflow_err, 1);
    chk("ovf_count", free_count, 96);
    alloc_req = 2'b11;
    settle();
    chk("ovf_nowrite_l0", alloc_preg[0], 32);
    chk("ovf_nowrite_l1", alloc_preg[1], 33);
    tick();
    chk("ovf_hold", overflow_err, 1);
    chk("ovf_ckpt", checkpoint_ptr, 2);
    chk("ovf_cnt2", free_count, 94);

    // Reset overrides restore, alloc and free in the same cycle
    rst = 1'b1; alloc_req = 2'b11; free_en = 2'b11; free_preg[0] = 7'd1; free_preg[1] = 7'd2;
    restore_en = 1'b1; restore_ptr = 8'd5;
    tick();
    rst = 1'b0;
    idle();
    settle();
    chk("rst2_ckpt", checkpoint_ptr, 0);
    chk("rst2_count", free_count, 96);
    chk("rst2_ovf", overflow_err, 0);

    // Drain with 2-lane groups: p32..p127 in order
    for (int c = 0; c < 48; c++) begin
      alloc_req = 2'b11;
      settle();
      chk("drain_l0", alloc_preg[0], 32 + 2 * c);
      chk("drain_l1", alloc_preg[1], 33 + 2 * c);
      chk("drain_stall", alloc_stall, 0);
      chk("drain_ckpt", checkpoint_ptr, 2 * c);
      chk("drain_count", free_count, 96 - 2 * c);
      tick();
    end
    chk("empty_count", free_count, 0);
    alloc_req = 2'b01;
    settle();
    chk("empty_stall_k1", alloc_stall, 1);
    alloc_req = 2'b11;
    settle();
    chk("empty_stall_k2", alloc_stall, 1);
    tick();
    idle();
    settle();
    chk("empty_ckpt_hold", checkpoint_ptr, 96);
    chk("empty_count_hold", free_count, 0);
`ifdef FREE_LIST_STATS_EN
    chk("stat_stalls", stall_cycles, 1);
    chk("stat_min", min_free_count, 0);
`endif

    // Free p5,p9 while empty; no same-cycle bypass
    free_en = 2'b11; free_preg[0] = 7'd5; free_preg[1] = 7'd9; alloc_req = 2'b01;
    settle();
    chk("nobypass_stall", alloc_stall, 1);
    tick();
    idle();
    settle();
    chk("free2_count", free_count, 2);
    chk("free2_ckpt", checkpoint_ptr, 96);
    alloc_req = 2'b01;
    settle();
    chk("realloc_p5", alloc_preg[0], 5);
    chk("realloc_stall0", alloc_stall, 0);
    tick();
    chk("cnt1_count", free_count, 1);
    alloc_req = 2'b11;
    settle();
    chk("cnt1_stall_k2", alloc_stall, 1);
    alloc_req = 2'b10;
    settle();
    chk("cnt1_stall_lane1", alloc_stall, 0);
    chk("realloc_p9_lane1", alloc_preg[1], 9);
    tick();
    idle();
    settle();
    chk("cnt0_count", free_count, 0);
    chk("cnt0_ckpt", checkpoint_ptr, 98);

    // Free p0..p19, allocate 10, checkpoint, allocate 6, restore with a free
    for (int c = 0; c < 10; c++) begin
      free_en = 2'b11; free_preg[0] = 7'(2 * c); free_preg[1] = 7'(2 * c + 1);
      tick();
    end
    idle();
    settle();
    chk("refill_count", free_count, 20);
    for (int c = 0; c < 8; c++) begin
      alloc_req = 2'b11;
      settle();
      chk("ck_l0", alloc_preg[0], 2 * c);
      chk("ck_l1", alloc_preg[1], 2 * c + 1);
      tick();
      if (c == 4) chk("ck_P", checkpoint_ptr, 108);
    end
    idle();
    settle();
    chk("pre_restore_ckpt", checkpoint_ptr, 114);
    chk("pre_restore_count", free_count, 4);
    restore_en = 1'b1; restore_ptr = 8'd108; alloc_req = 2'b11;
    free_en = 2'b01; free_preg[0] = 7'd100;
    settle();
    chk("restore_nostall", alloc_stall, 0);
    tick();
    idle();
    settle();
    chk("restore_ckpt", checkpoint_ptr, 108);
    chk("restore_count", free_count, 11);
    alloc_req = 2'b11;
    settle();
    chk("restore_l0", alloc_preg[0], 10);
    chk("restore_l1", alloc_preg[1], 11);
    idle();

    // Pointer wrap 191 -> 0 with index group 95 -> 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    alloc_req = 2'b01;
    settle();
    chk("wrap_first", alloc_preg[0], 32);
    tick();
    for (int c = 0; c < 95; c++) begin
      alloc_req = 2'b11; free_en = 2'b11;
      free_preg[0] = 7'(c); free_preg[1] = 7'(127 - c);
      settle();
      chk("wrap_ckpt", checkpoint_ptr, 1 + 2 * c);
      chk("wrap_count", free_count, 95);
      if (c < 48) begin
        chk("wrap_l0", alloc_preg[0], 33 + 2 * c);
        chk("wrap_l1", alloc_preg[1], (c == 47) ? 0 : 34 + 2 * c);
      end
      tick();
    end
    idle();
    alloc_req = 2'b11;
    settle();
    chk("wrap191_ckpt", checkpoint_ptr, 191);
    chk("wrap191_l0", alloc_preg[0], 80);
    chk("wrap191_l1", alloc_preg[1], 48);
    chk("wrap191_stall", alloc_stall, 0);
    tick();
    idle();
    settle();
    chk("wrap_after_ckpt", checkpoint_ptr, 1);
    chk("wrap_after_count", free_count, 93);
    chk("wrap_ovf", overflow_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
